// File: rtl/riscv_pkg.sv
// Shared RV64 decode definitions: opcodes, ALUOp encodings, control bundle and
// decode helpers used by decode_stage.
package riscv_pkg;

  localparam logic [6:0] OpcRtype  = 7'b0110011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  typedef enum logic [1:0] {
    AluLdSt  = 2'b00,
    AluBr    = 2'b01,
    AluRtype = 2'b10
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
  } ctrl_t;

  localparam ctrl_t CtrlNop = '{AluLdSt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
    ctrl_t c;
    c = CtrlNop;
    case (opcode)
      OpcRtype: begin
        c.alu_op    = AluRtype;
        c.reg_write = 1'b1;
      end
      OpcLoad: begin
        c.alu_op     = AluLdSt;
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      OpcStore: begin
        c.alu_op    = AluLdSt;
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      OpcBranch: begin
        c.alu_op = AluBr;
        c.branch = 1'b1;
      end
      default: c = CtrlNop;
    endcase
    return c;
  endfunction

  // Branch offset stays in halfword units; execute applies the <<1.
  function automatic logic [63:0] decode_imm(input logic [31:0] instr);
    logic [63:0] imm;
    case (instr[6:0])
      OpcLoad:   imm = {{52{instr[31]}}, instr[31:20]};
      OpcStore:  imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      OpcBranch: imm = {{52{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8]};
      default:   imm = 64'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32 x 64-bit register file: two async read ports, one sync write port, x0 fixed at 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [63:0] o_rdata1,
  output logic [63:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [63:0] i_wdata
);

  logic [63:0] r_regs [32];
  logic        w_wr_en;

  assign w_wr_en = i_we && (i_waddr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 64'd0;
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = (i_raddr1 == 5'd0) ? 64'd0 : r_regs[i_raddr1];
    o_rdata2 = (i_raddr2 == 5'd0) ? 64'd0 : r_regs[i_raddr2];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
    if (w_wr_en && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// RV64 decode stage: register read, immediate/control decode and the ID/EX register.
// REGFILE_BYPASS_EN selects write-through register reads inside regfile.
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [63:0] if_pc,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [63:0] A,
  output logic [63:0] B,
  output logic [63:0] C,
  output logic [63:0] PC,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [1:0]  ALUOp,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        Branch
);

  logic [63:0] w_rs1_data, w_rs2_data;
  logic        w_load;
  logic        r_valid;
  ctrl_t       r_ctrl;
  logic [63:0] r_a, r_b, r_c, r_pc;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic [4:0]  r_rd;

  regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr1 (if_instr[19:15]),
    .i_raddr2 (if_instr[24:20]),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data),
    .i_we     (wb_we),
    .i_waddr  (wb_rd),
    .i_wdata  (wb_data)
  );

  assign id_ready = !r_valid || ex_ready;
  assign w_load   = if_valid && id_ready && !flush;

  // Flush wins over a load; a drained entry keeps its stale fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_ctrl   <= CtrlNop;
      r_a      <= 64'd0;
      r_b      <= 64'd0;
      r_c      <= 64'd0;
      r_pc     <= 64'd0;
      r_funct3 <= 3'd0;
      r_funct7 <= 7'd0;
      r_rd     <= 5'd0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= CtrlNop;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_ctrl   <= decode_ctrl(if_instr[6:0]);
      r_a      <= w_rs1_data;
      r_b      <= w_rs2_data;
      r_c      <= decode_imm(if_instr);
      r_pc     <= if_pc;
      r_funct3 <= if_instr[14:12];
      r_funct7 <= if_instr[31:25];
      r_rd     <= if_instr[11:7];
    end else if (ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign ex_valid = r_valid;
  assign A        = r_a;
  assign B        = r_b;
  assign C        = r_c;
  assign PC       = r_pc;
  assign funct3   = r_funct3;
  assign funct7   = r_funct7;
  assign rd       = r_rd;
  assign ALUOp    = r_ctrl.alu_op;
  assign ALUSrc   = r_ctrl.alu_src;
  assign RegWrite = r_ctrl.reg_write;
  assign MemRead  = r_ctrl.mem_read;
  assign MemWrite = r_ctrl.mem_write;
  assign MemtoReg = r_ctrl.mem_to_reg;
  assign Branch   = r_ctrl.branch;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against a behavioural pipeline/register-file model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;
  logic        ex_ready;
  logic        id_ready;
  logic        ex_valid;
  logic [63:0] A, B, C, PC;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [1:0]  ALUOp;
  logic        ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .flush    (flush),
    .ex_ready (ex_ready),
    .id_ready (id_ready),
    .ex_valid (ex_valid),
    .A        (A),
    .B        (B),
    .C        (C),
    .PC       (PC),
    .funct3   (funct3),
    .funct7   (funct7),
    .rd       (rd),
    .ALUOp    (ALUOp),
    .ALUSrc   (ALUSrc),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .MemtoReg (MemtoReg),
    .Branch   (Branch)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [63:0] model_rf [32];
  logic        e_valid;
  logic        e_flushed;
  logic [63:0] e_a, e_b, e_c, e_pc;
  logic [2:0]  e_f3;
  logic [6:0]  e_f7;
  logic [4:0]  e_rd;
  logic [7:0]  e_ctrl;  // {ALUOp, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch}

  localparam logic [31:0] InstrAdd = 32'h002081B3;
  localparam logic [31:0] InstrLd  = 32'hFF80B283;
  localparam logic [31:0] InstrBeq = 32'hFE208EE3;

  function automatic logic [63:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (wb_we && wb_rd == idx) return wb_data;
`endif
    return model_rf[idx];
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] ins);
    logic [11:0] f;
    longint      v;
    f = 12'd0;
    case (ins[6:0])
      7'b0000011: f = ins[31:20];
      7'b0100011: f = {ins[31:25], ins[11:7]};
      7'b1100011: f = {ins[31], ins[7], ins[30:25], ins[11:8]};
      default:    f = 12'd0;
    endcase
    v = longint'(f);
    if (f[11]) v = v - 4096;
    return v;
  endfunction

  function automatic logic [7:0] ref_ctrl(input logic [6:0] opc);
    case (opc)
      7'b0110011: return 8'b10_0_1_0_0_0_0;
      7'b0000011: return 8'b00_1_1_1_0_1_0;
      7'b0100011: return 8'b00_1_0_0_1_0_0;
      7'b1100011: return 8'b01_0_0_0_0_0_1;
      default:    return 8'b00_0_0_0_0_0_0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_rf[i] = 64'd0;
    e_valid = 1'b0; e_flushed = 1'b1; e_ctrl = 8'd0;
    e_a = 64'd0; e_b = 64'd0; e_c = 64'd0; e_pc = 64'd0;
    e_f3 = 3'd0; e_f7 = 7'd0; e_rd = 5'd0;
  endtask

  task automatic model_next();
    if (flush) begin
      e_valid = 1'b0; e_ctrl = 8'd0; e_flushed = 1'b1;
    end else if (if_valid && (!e_valid || ex_ready)) begin
      e_valid = 1'b1; e_flushed = 1'b0;
      e_a  = ref_read(if_instr[19:15]);
      e_b  = ref_read(if_instr[24:20]);
      e_c  = ref_imm(if_instr);
      e_pc = if_pc;
      e_f3 = if_instr[14:12];
      e_f7 = if_instr[31:25];
      e_rd = if_instr[11:7];
      e_ctrl = ref_ctrl(if_instr[6:0]);
    end else if (ex_ready) begin
      e_valid = 1'b0;
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
    if (wb_we && wb_rd != 5'd0) model_rf[wb_rd] = wb_data;
  endtask

  task automatic idle();
    if_valid = 1'b0; wb_we = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    tick();
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [63:0] d);
    wb_we = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
    if_valid = 1'b1; if_instr = ins; if_pc = pc; ex_ready = 1'b1;
    tick();
    if_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_valid = 1'b0; if_instr = 32'd0; if_pc = 64'd0; wb_we = 1'b0; wb_rd = 5'd0;
    wb_data = 64'd0; flush = 1'b0; ex_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    n_checks++;
    if ({A, B, C, PC} !== 256'd0) begin
      n_fail++; $display("FAIL reset_datapath got=%h %h %h %h exp=0", A, B, C, PC);
    end
    n_checks++;
    if ({ALUOp, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch} !== 8'd0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=0", {ALUOp, ALUSrc, RegWrite});
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_id_ready got=%b exp=1", id_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    write_reg(5'd1, 64'h0000_0000_0000_0005);
    write_reg(5'd2, 64'h3);
    issue(InstrAdd, 64'h1000);
    n_checks++;
    if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL add_ex_valid got=%b exp=1", ex_valid); end
    n_checks++;
    if (A !== 64'd5) begin n_fail++; $display("FAIL add_A got=%h exp=5", A); end
    n_checks++;
    if (B !== 64'd3) begin n_fail++; $display("FAIL add_B got=%h exp=3", B); end
    n_checks++;
    if ({ALUOp, ALUSrc, RegWrite} !== 4'b10_0_1) begin
      n_fail++; $display("FAIL add_ctrl got=%b exp=1001", {ALUOp, ALUSrc, RegWrite});
    end
    n_checks++;
    if (rd !== 5'd3) begin n_fail++; $display("FAIL add_rd got=%0d exp=3", rd); end
    idle();
  endtask

  task automatic test_ld();
    issue(InstrLd, 64'h2000);
    n_checks++;
    if (C !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      n_fail++; $display("FAIL ld_C got=%h exp=fffffffffffffff8", C);
    end
    n_checks++;
    if ({ALUSrc, MemRead, MemtoReg, RegWrite, MemWrite} !== 5'b11110) begin
      n_fail++; $display("FAIL ld_ctrl got=%b exp=11110", {ALUSrc, MemRead, MemtoReg, RegWrite, MemWrite});
    end
    n_checks++;
    if (rd !== 5'd5 || A !== 64'd5) begin n_fail++; $display("FAIL ld_rd_A got=%0d %h exp=5 5", rd, A); end
    idle();
  endtask

  task automatic test_beq();
    logic [63:0] target;
    issue(InstrBeq, 64'h3000);
    n_checks++;
    if (C !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++; $display("FAIL beq_C got=%h exp=fffffffffffffffe", C);
    end
    n_checks++;
    if ({Branch, ALUOp, RegWrite, ALUSrc} !== 5'b1_01_0_0) begin
      n_fail++; $display("FAIL beq_ctrl got=%b exp=10100", {Branch, ALUOp, RegWrite, ALUSrc});
    end
    target = PC + (C << 1);
    n_checks++;
    if (target !== 64'h3000 - 64'd4) begin n_fail++; $display("FAIL beq_target got=%h exp=2ffc", target); end
    idle();
  endtask

  task automatic test_stall();
    issue(InstrAdd, 64'h4000);
    ex_ready = 1'b0; if_valid = 1'b1; if_instr = InstrLd; if_pc = 64'h4004;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (id_ready !== 1'b0) begin n_fail++; $display("FAIL stall_id_ready got=%b exp=0", id_ready); end
      n_checks++;
      if ({ex_valid, A, B, rd, RegWrite, MemRead, PC} !== {1'b1, 64'd5, 64'd3, 5'd3, 1'b1, 1'b0, 64'h4000})
      begin
        n_fail++; $display("FAIL stall_hold got=%b %h %h %0d %h exp=1 5 3 3 4000", ex_valid, A, B, rd, PC);
      end
    end
    ex_ready = 1'b1;
    tick();
    if_valid = 1'b0;
    n_checks++;
    if ({ex_valid, MemRead, rd, PC} !== {1'b1, 1'b1, 5'd5, 64'h4004}) begin
      n_fail++; $display("FAIL stall_release got=%b %b %0d %h exp=1 1 5 4004", ex_valid, MemRead, rd, PC);
    end
    idle();
  endtask

  task automatic test_flush();
    issue(InstrLd, 64'h5000);
    if_valid = 1'b1; if_instr = InstrAdd; flush = 1'b1;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ex_valid got=%b exp=0", ex_valid); end
    n_checks++;
    if ({ALUOp, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch} !== 8'd0) begin
      n_fail++;
      $display("FAIL flush_ctrl got=%b exp=0", {ALUOp, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch});
    end
    idle();
  endtask

  task automatic test_x0();
    write_reg(5'd0, 64'hDEAD);
    issue({7'd0, 5'd0, 5'd0, 3'd0, 5'd7, 7'b0110011}, 64'h6000);
    n_checks++;
    if (A !== 64'd0 || B !== 64'd0) begin n_fail++; $display("FAIL x0_read got=%h %h exp=0 0", A, B); end
    idle();
  endtask

  task automatic test_bypass();
    logic [63:0] exp_b;
    write_reg(5'd4, 64'h1111);
    wb_we = 1'b1; wb_rd = 5'd4; wb_data = 64'h2222;
    issue({7'd0, 5'd4, 5'd0, 3'd0, 5'd6, 7'b0110011}, 64'h7000);
    wb_we = 1'b0;
`ifdef REGFILE_BYPASS_EN
    exp_b = 64'h2222;
`else
    exp_b = 64'h1111;
`endif
    n_checks++;
    if (B !== exp_b) begin n_fail++; $display("FAIL bypass_B got=%h exp=%h", B, exp_b); end
    issue({7'd0, 5'd4, 5'd0, 3'd0, 5'd6, 7'b0110011}, 64'h7004);
    n_checks++;
    if (B !== 64'h2222) begin n_fail++; $display("FAIL bypass_commit got=%h exp=2222", B); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [6:0]  opcs [5];
    opcs[0] = 7'b0110011; opcs[1] = 7'b0000011; opcs[2] = 7'b0100011;
    opcs[3] = 7'b1100011; opcs[4] = 7'b0010011;
    for (int i = 0; i < 400; i++) begin
      ins      = $urandom();
      ins[6:0] = opcs[$urandom_range(0, 4)];
      if_instr = ins;
      if_pc    = {$urandom(), $urandom()};
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      wb_we    = $urandom_range(0, 1) == 1;
      wb_rd    = 5'($urandom_range(0, 31));
      wb_data  = {$urandom(), $urandom()};
      tick();
      n_checks++;
      if (ex_valid !== e_valid) begin n_fail++; $display("FAIL rand_ex_valid got=%b exp=%b", ex_valid, e_valid); end
      n_checks++;
      if (id_ready !== (!e_valid || ex_ready)) begin
        n_fail++; $display("FAIL rand_id_ready got=%b exp=%b", id_ready, !e_valid || ex_ready);
      end
      if (e_valid || e_flushed) begin
        n_checks++;
        if ({ALUOp, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch} !== e_ctrl) begin
          n_fail++;
          $display("FAIL rand_ctrl got=%b exp=%b",
                   {ALUOp, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch}, e_ctrl);
        end
      end
      if (e_valid) begin
        n_checks++;
        if ({A, B, C, PC, funct3, funct7, rd} !== {e_a, e_b, e_c, e_pc, e_f3, e_f7, e_rd}) begin
          n_fail++;
          $display("FAIL rand_datapath got=%h %h %h %h %h %h %h exp=%h %h %h %h %h %h %h",
                   A, B, C, PC, funct3, funct7, rd, e_a, e_b, e_c, e_pc, e_f3, e_f7, e_rd);
        end
      end
    end
    wb_we = 1'b0;
    idle();
  endtask

  task automatic test_reset_mid_stall();
    write_reg(5'd1, 64'h55);
    issue(InstrAdd, 64'h8000);
    ex_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ex_valid !== 1'b0 || A !== 64'd0 || RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL midreset_discard got=%b %h %b exp=0 0 0", ex_valid, A, RegWrite);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    issue(InstrAdd, 64'h8004);
    n_checks++;
    if (ex_valid !== 1'b1 || A !== 64'd0) begin
      n_fail++; $display("FAIL midreset_rf_cleared got=%b %h exp=1 0", ex_valid, A);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld();
    test_beq();
    test_stall();
    test_flush();
    test_x0();
    test_bypass();
    test_random();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
